output_layer_tx: RTL

Transmit end of the DNN layer interface. It captures one 4-neuron result vector from the final layer when input_ready is asserted. It then streams the four values, one per beat, over a valid/ready interface to the host or scoreboard. Back-to-back vectors are supported, and dropped vectors are flagged.

---
 rtl/dnn_pkg.sv | 10 +
 rtl/output_layer_tx_if.sv | 34 +++
 rtl/output_layer_tx_argmax_tracker.sv | 37 +++
 rtl/output_layer_tx.sv | 67 ++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// dnn_pkg: shared neuron value, index and tx state types for the DNN layer interface
package dnn_pkg;
    localparam int DATA_W    = 5;
    localparam int N_NEURONS = 4;
    localparam int IDX_W     = $clog2(N_NEURONS);

    typedef logic signed [DATA_W-1:0] neuron_t;
    typedef logic [IDX_W-1:0]         idx_t;
    typedef enum logic {IDLE, SEND}   tx_state_t;
endpackage

// File: rtl/output_layer_tx_if.sv
// output_layer_tx_if: vector capture and beat stream signals; OUTPUT_LAYER_ARGMAX_EN adds class_idx/class_valid
interface output_layer_tx_if;
    import dnn_pkg::*;
    logic    input_ready;
    neuron_t in0, in1, in2, in3;
    logic    in_accept;
    neuron_t out_data;
    idx_t    out_idx;
    logic    out_valid;
    logic    out_ready;
    logic    out_last;
    logic    overrun;
`ifdef OUTPUT_LAYER_ARGMAX_EN
    idx_t    class_idx;
    logic    class_valid;
    modport master (
        input  input_ready, in0, in1, in2, in3, out_ready,
        output in_accept, out_data, out_idx, out_valid, out_last, overrun, class_idx, class_valid
    );
    modport slave (
        output input_ready, in0, in1, in2, in3, out_ready,
        input  in_accept, out_data, out_idx, out_valid, out_last, overrun, class_idx, class_valid
    );
`else
    modport master (
        input  input_ready, in0, in1, in2, in3, out_ready,
        output in_accept, out_data, out_idx, out_valid, out_last, overrun
    );
    modport slave (
        output input_ready, in0, in1, in2, in3, out_ready,
        input  in_accept, out_data, out_idx, out_valid, out_last, overrun
    );
`endif
endinterface

// File: rtl/output_layer_tx_argmax_tracker.sv
// argmax_tracker: running signed max over transferred beats; ties keep the lower index
module argmax_tracker
    import dnn_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    beat,
    input  neuron_t value,
    input  idx_t    index,
    input  logic    first,
    input  logic    last,
    output idx_t    class_idx,
    output logic    class_valid
);
    neuron_t max_q;
    idx_t    arg_q;
    logic    take;

    assign take = first || (value > max_q);

    // track the best beat so far and publish it one cycle after the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q       <= '0;
            arg_q       <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= beat && last;
            if (beat && take) begin
                max_q <= value;
                arg_q <= index;
            end
            if (beat && last) class_idx <= take ? index : arg_q;
        end
    end
endmodule

// File: rtl/output_layer_tx.sv
// output_layer_tx: captures a 4-neuron vector and streams it one beat per handshake; OUTPUT_LAYER_ARGMAX_EN adds argmax
module output_layer_tx
    import dnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output_layer_tx_if.master bus
);
    tx_state_t state_q, state_d;
    neuron_t   vec_q [N_NEURONS];
    idx_t      idx_q;
    logic      overrun_q;
    logic      send, last_beat, xfer, accept, capture;

    // state register; async reset drops out_valid immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state and beat outputs; in_accept is combinational from out_ready so the last beat can overlap a capture
    always_comb begin
        send          = state_q == SEND;
        last_beat     = idx_q == idx_t'(N_NEURONS - 1);
        xfer          = send && bus.out_ready;
        accept        = !send || (last_beat && bus.out_ready);
        capture       = bus.input_ready && accept;
        state_d       = capture ? SEND : (xfer && last_beat) ? IDLE : state_q;
        bus.in_accept = accept;
        bus.out_valid = send;
        bus.out_data  = send ? vec_q[idx_q] : '0;
        bus.out_idx   = send ? idx_q : '0;
        bus.out_last  = send && last_beat;
        bus.overrun   = overrun_q;
    end

    // capture buffer, beat index and sticky overrun on a refused vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '{default: '0};
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.input_ready && !accept) overrun_q <= 1'b1;
            if (capture) begin
                vec_q <= '{bus.in0, bus.in1, bus.in2, bus.in3};
                idx_q <= '0;
            end else if (xfer) begin
                idx_q <= idx_q + idx_t'(1);
            end
        end
    end

`ifdef OUTPUT_LAYER_ARGMAX_EN
    argmax_tracker u_argmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat        (xfer),
        .value       (bus.out_data),
        .index       (idx_q),
        .first       (idx_q == '0),
        .last        (last_beat),
        .class_idx   (bus.class_idx),
        .class_valid (bus.class_valid)
    );
`endif
endmodule
